// File: rtl/axi_reg_responder.sv
// axi_reg_responder: AXI4 single-beat slave over a small register bank.
// Words: 0 ctrl (RW, drives ctrl_out), 1 status_in, 2 ID_VALUE,
// 3 free-running cycle counter, 4..NUM_REGS-1 scratch (RW).
// Ports: clk, rst (async, active high), s_axi_aw*/w*/b* write channels,
// s_axi_ar*/r* read channels, ctrl_out (reg0[7:0]), status_in.
// Macro AXI_REG_DECERR_EN: out-of-range accesses answer DECERR instead
// of aliasing onto the word index.
module axi_reg_responder #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          ID_WIDTH   = 1,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'hA7C0_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            ctrl_out,
  input  logic [7:0]            status_in
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int SH = 2 + IW;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
`ifdef AXI_REG_DECERR_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a >> SH) == '0;
  endfunction

  logic [31:0] bank [NUM_REGS];
  logic [31:0] cnt;

  // ---------------- write side ----------------
  wr_state_e           wr_q, wr_d;
  logic                aw_held, w_held;
  logic                aw_held_d, w_held_d;
  logic [IW-1:0]       aw_idx_q;
  logic                aw_ok_q;
  logic [ID_WIDTH-1:0] awid_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                wlast_q;
  logic                aw_hs, w_hs, aw_have, w_have;
  logic [IW-1:0]       cur_idx;
  logic                cur_ok, cur_last;
  logic [ID_WIDTH-1:0] cur_id;
  logic [31:0]         cur_data;
  logic [3:0]          cur_strb;
  logic                commit, wr_word;
  logic                awready_d, wready_d, bvalid_d;
  logic [1:0]          bresp_d;
  logic [ID_WIDTH-1:0] bid_d;

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign aw_have = aw_held | aw_hs;
  assign w_have  = w_held | w_hs;

  // A channel handshaking this edge bypasses its capture register
  assign cur_idx  = aw_hs ? s_axi_awaddr[2 +: IW] : aw_idx_q;
  assign cur_ok   = aw_hs ? in_range(s_axi_awaddr) : aw_ok_q;
  assign cur_id   = aw_hs ? s_axi_awid : awid_q;
  assign cur_data = w_hs ? s_axi_wdata : wdata_q;
  assign cur_strb = w_hs ? s_axi_wstrb : wstrb_q;
  assign cur_last = w_hs ? s_axi_wlast : wlast_q;

  // Words 1..3 are read-only: the write is acknowledged, not stored
  assign wr_word = commit &&
    (cur_idx == '0 || cur_idx > IW'(3));

  always_comb begin
    wr_d      = wr_q;
    awready_d = s_axi_awready;
    wready_d  = s_axi_wready;
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    bid_d     = s_axi_bid;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    commit    = 1'b0;
    unique case (wr_q)
      WR_IDLE: begin
        if (aw_have && w_have) begin
          wr_d      = WR_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bid_d     = cur_id;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (!cur_last) begin
            bresp_d = SLVERR;
          end else if (DEC_EN && !cur_ok) begin
            bresp_d = DECERR;
          end else begin
            bresp_d = OKAY;
            commit  = 1'b1;
          end
        end else begin
          awready_d = !aw_have;
          wready_d  = !w_have;
          aw_held_d = aw_have;
          w_held_d  = w_have;
        end
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          wr_d      = WR_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q          <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_bid     <= '0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
    end else begin
      wr_q          <= wr_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      s_axi_bid     <= bid_d;
      aw_held       <= aw_held_d;
      w_held        <= w_held_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      awid_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_idx_q <= s_axi_awaddr[2 +: IW];
        aw_ok_q  <= in_range(s_axi_awaddr);
        awid_q   <= s_axi_awid;
      end
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
        wlast_q <= s_axi_wlast;
      end
    end
  end

  // ---------------- register bank ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank[i] <= '0;
      end
      cnt      <= '0;
      ctrl_out <= '0;
    end else begin
      cnt      <= cnt + 32'd1;
      ctrl_out <= bank[0][7:0];
      if (wr_word) begin
        for (int b = 0; b < 4; b++) begin
          if (cur_strb[b]) begin
            bank[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------- read side ----------------
  rd_state_e           rd_q, rd_d;
  logic                ar_hs, rd_ok;
  logic [IW-1:0]       rd_idx;
  logic [31:0]         rd_word;
  logic                arready_d, rvalid_d;
  logic [31:0]         rdata_d;
  logic [1:0]          rresp_d;
  logic [ID_WIDTH-1:0] rid_d;

  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign rd_idx = s_axi_araddr[2 +: IW];
  assign rd_ok  = in_range(s_axi_araddr);
  assign s_axi_rlast = s_axi_rvalid;

  always_comb begin
    rd_word = bank[rd_idx];
    unique case (1'b1)
      rd_idx == IW'(1): rd_word = {24'b0, status_in};
      rd_idx == IW'(2): rd_word = ID_VALUE;
      rd_idx == IW'(3): rd_word = cnt;
      default: ;
    endcase
  end

  always_comb begin
    rd_d      = rd_q;
    arready_d = s_axi_arready;
    rvalid_d  = s_axi_rvalid;
    rdata_d   = s_axi_rdata;
    rresp_d   = s_axi_rresp;
    rid_d     = s_axi_rid;
    unique case (rd_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rd_d      = RD_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_axi_arid;
          if (DEC_EN && !rd_ok) begin
            rdata_d = '0;
            rresp_d = DECERR;
          end else begin
            rdata_d = rd_word;
            rresp_d = OKAY;
          end
        end
      end
      RD_DATA: begin
        if (s_axi_rready) begin
          rd_d      = RD_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q          <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      s_axi_rid     <= '0;
    end else begin
      rd_q          <= rd_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
      s_axi_rid     <= rid_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                         rd_ok, cur_ok};

endmodule

// File: tb/tb_axi_reg_responder.sv
// tb_axi_reg_responder: randomized AXI traffic against a word-level
// model of the register bank, plus directed handshake/reset cases.
module tb_axi_reg_responder;

`ifdef AXI_REG_DECERR_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  localparam logic [31:0] ID_V = 32'hA7C0_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  s_axi_awid = '0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [0:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [0:0]  s_axi_arid = '0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [0:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [7:0]  ctrl_out;
  logic [7:0]  status_in = '0;

  axi_reg_responder dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .ctrl_out(ctrl_out),
    .status_in(status_in)
  );

  always #5 clk = ~clk;

  // Reference: clock edges seen since reset released
  logic [31:0] tb_cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  logic [31:0] mregs [8];
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_hs;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    case (idx)
      1:       return {24'b0, status_in};
      2:       return ID_V;
      3:       return tb_cyc - 32'd1;
      default: return mregs[idx];
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {27'b0, 3'($urandom_range(0, 7)), 2'($urandom)};
    if ($urandom_range(0, 5) == 0) a[$urandom_range(5, 31)] = 1'b1;
    return a;
  endfunction

  task automatic axi_write(input logic [31:0] addr,
                           input logic [31:0] data,
                           input logic [3:0] strb, input logic last,
                           input logic id, input int aw_dly,
                           input int w_dly, input int b_dly);
    bit aw_done, w_done, hs_aw, hs_w, ok;
    int c, idx;
    logic [1:0] er;
    logic [7:0] old_ctrl;
    aw_done = 0; w_done = 0; c = 0;
    s_axi_awaddr = addr; s_axi_awid = id;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last;
    old_ctrl = mregs[0][7:0];
    while (!(aw_done && w_done) && c < 40) begin
      s_axi_awvalid = !aw_done && (c >= aw_dly);
      s_axi_wvalid  = !w_done && (c >= w_dly);
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); @(negedge clk);
      aw_done |= hs_aw;
      w_done  |= hs_w;
      if (!(aw_done && w_done)) begin
        chk("bvalid_early", s_axi_bvalid, 0);
        if (aw_done) chk("awready_held", s_axi_awready, 0);
        if (w_done) chk("wready_held", s_axi_wready, 0);
      end
      c++;
    end
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    if (!(aw_done && w_done)) begin
      chk("wr_timeout", 0, 1);
      return;
    end
    idx = int'(addr[4:2]);
    ok  = (addr >> 5) == 0;
    if (!last)          er = 2'b10;
    else if (DEC && !ok) er = 2'b11;
    else                er = 2'b00;
    chk("bvalid", s_axi_bvalid, 1);
    chk("bid", s_axi_bid, id);
    chk("bresp", s_axi_bresp, er);
    chk("awready_resp", s_axi_awready, 0);
    chk("wready_resp", s_axi_wready, 0);
    chk("ctrl_not_yet", ctrl_out, old_ctrl);
    if (er == 2'b00 && (idx == 0 || idx >= 4))
      for (int b = 0; b < 4; b++)
        if (strb[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); @(negedge clk);
      chk("bvalid_hold", s_axi_bvalid, 1);
      chk("bid_hold", s_axi_bid, id);
      chk("bresp_hold", s_axi_bresp, er);
      chk("awready_hold", s_axi_awready, 0);
      chk("wready_hold", s_axi_wready, 0);
    end
    s_axi_bready = 1;
    @(posedge clk); @(negedge clk);
    s_axi_bready = 0;
    chk("bvalid_clr", s_axi_bvalid, 0);
    chk("awready_back", s_axi_awready, 1);
    chk("wready_back", s_axi_wready, 1);
    chk("ctrl_out", ctrl_out, mregs[0][7:0]);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic id,
                          input int ar_dly, input int r_dly,
                          output logic [31:0] got);
    bit hs, ok;
    int c, idx;
    logic [31:0] ed;
    logic [1:0] er;
    hs = 0; c = 0; got = '0;
    s_axi_araddr = addr; s_axi_arid = id;
    while (!hs && c < 40) begin
      s_axi_arvalid = c >= ar_dly;
      hs = s_axi_arvalid && s_axi_arready;
      @(posedge clk); @(negedge clk);
      c++;
    end
    s_axi_arvalid = 0;
    if (!hs) begin
      chk("rd_timeout", 0, 1);
      return;
    end
    last_hs = tb_cyc - 32'd1;
    idx = int'(addr[4:2]);
    ok  = (addr >> 5) == 0;
    if (DEC && !ok) begin
      ed = '0; er = 2'b11;
    end else begin
      ed = model_word(idx); er = 2'b00;
    end
    got = s_axi_rdata;
    chk("rvalid", s_axi_rvalid, 1);
    chk("rlast", s_axi_rlast, 1);
    chk("rid", s_axi_rid, id);
    chk("rdata", s_axi_rdata, ed);
    chk("rresp", s_axi_rresp, er);
    chk("arready_data", s_axi_arready, 0);
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); @(negedge clk);
      chk("rvalid_hold", s_axi_rvalid, 1);
      chk("rdata_hold", s_axi_rdata, ed);
      chk("rresp_hold", s_axi_rresp, er);
      chk("arready_hold", s_axi_arready, 0);
    end
    s_axi_rready = 1;
    @(posedge clk); @(negedge clk);
    s_axi_rready = 0;
    chk("rvalid_clr", s_axi_rvalid, 0);
    chk("arready_back", s_axi_arready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r1, r2, t1, rd;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    #1;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_ids", {s_axi_bid, s_axi_rid}, 0);
    chk("rst_ctrl", ctrl_out, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("rdy_at_release", s_axi_awready, 0);
    @(negedge clk);
    chk("rdy_aw_up", s_axi_awready, 1);
    chk("rdy_w_up", s_axi_wready, 1);
    chk("rdy_ar_up", s_axi_arready, 1);

    axi_write(32'h0, 32'h5A, 4'hF, 1, 1, 0, 0, 0);
    axi_write(32'h10, 32'h11223344, 4'b0101, 1, 0, 2, 0, 0);
    axi_read(32'h10, 0, 0, 0, rd);
    axi_read(32'h8, 1, 0, 0, rd);
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 1, 0, 0, 1, 0);
    axi_read(32'h8, 0, 0, 0, rd);
    status_in = 8'hC3;
    axi_read(32'h4, 0, 0, 0, rd);
    axi_write(32'h14, 32'hCAFE0123, 4'hF, 1, 1, 1, 0, 5);
    axi_read(32'h14, 1, 0, 5, rd);
    axi_write(32'h18, 32'h12345678, 4'hF, 0, 1, 0, 0, 1);
    axi_read(32'h100, 0, 0, 0, rd);

    axi_read(32'hC, 0, 0, 0, r1);
    t1 = last_hs;
    repeat (7) @(negedge clk);
    axi_read(32'hC, 0, 0, 0, r2);
    chk("cnt_diff", r2 - r1, last_hs - t1);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      a = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, $urandom, 4'($urandom),
                  $urandom_range(0, 7) != 0, 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      end else begin
        status_in = 8'($urandom);
        axi_read(a, 1'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 2), rd);
      end
    end

    axi_write(32'h0, 32'hA5, 4'hF, 1, 0, 0, 0, 0);
    s_axi_awaddr = 32'h0; s_axi_awid = 1;
    s_axi_wdata = 32'h3C; s_axi_wstrb = 4'hF; s_axi_wlast = 1;
    s_axi_awvalid = 1; s_axi_wvalid = 1;
    @(posedge clk); @(negedge clk);
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("pre_rst_bvalid", s_axi_bvalid, 1);
    chk("pre_rst_ctrl", ctrl_out, 8'hA5);
    #2 rst = 1;
    #1;
    chk("mid_rst_bvalid", s_axi_bvalid, 0);
    chk("mid_rst_ctrl", ctrl_out, 0);
    chk("mid_rst_awready", s_axi_awready, 0);
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_wready", s_axi_wready, 1);
    chk("post_rst_arready", s_axi_arready, 1);
    chk("post_rst_bvalid", s_axi_bvalid, 0);
    axi_read(32'h0, 0, 0, 0, rd);
    axi_read(32'h10, 0, 0, 0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
